// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and defaults for the memory-stage controller
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  // Snapshot of the EX/MEM register taken when a memory op is detected.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [REG_W_DEF-1:0]  rd;
    logic                  regw;
    logic                  we;
  } mem_req_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - cycle counter bounding how long a request may wait for ack
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // count REQ cycles from zero; parks at the last value so it never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - EX/MEM to data-memory req/ack controller with write-back outputs
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_regw,
  input  logic              ex_memw,
  input  logic              ex_memr,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_regw,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  state_t   state, state_nxt;
  mem_req_t lat_q;
  logic     is_mem;
  logic     latch_en;
  logic     ctr_clr;
  logic     ctr_en;
  logic     expired;

  assign is_mem = ex_memr | ex_memw;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and combinational handshake/stall controls
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    latch_en  = 1'b0;
    ctr_clr   = 1'b1;
    ctr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall     = 1'b1;
          latch_en  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        ctr_clr = 1'b0;
        ctr_en  = 1'b1;
        // ack beats the timeout when both land on the same cycle
        if (mem_ack || expired) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // capture the memory op so the request stays stable while upstream is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q <= '0;
    end else if (latch_en) begin
      lat_q.addr  <= ex_addr;
      lat_q.wdata <= ex_wdata;
      lat_q.rd    <= ex_rd;
      lat_q.regw  <= ex_regw;
      lat_q.we    <= ex_memw;
    end
  end

  assign mem_we    = lat_q.we;
  assign mem_addr  = lat_q.addr;
  assign mem_wdata = lat_q.wdata;

  // registered write-back hand-off and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_regw  <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem && ex_regw) begin
            wb_valid <= 1'b1;
            wb_regw  <= 1'b1;
            wb_rd    <= ex_rd;
            wb_data  <= ex_addr;
          end
        end
        REQ: begin
          if (mem_ack) begin
            wb_valid <= 1'b1;
            wb_rd    <= lat_q.rd;
            if (lat_q.we) begin
              wb_regw <= 1'b0;
              wb_data <= lat_q.addr;
            end else begin
              wb_regw <= lat_q.regw;
              wb_data <= mem_rdata;
            end
          end else if (expired) begin
            err      <= 1'b1;
            wb_valid <= 1'b1;
            wb_regw  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_regw, ex_memw, ex_memr;
  logic [DW-1:0] ex_addr, ex_wdata;
  logic [RW-1:0] ex_rd;
  logic          stall, mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid, wb_regw;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          err;

  mem_stage_ctrl #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_regw   (ex_regw),
    .ex_memw   (ex_memw),
    .ex_memr   (ex_memr),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_rd     (ex_rd),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_regw   (wb_regw),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          regw;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          full;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic model_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input logic regw, input logic [RW-1:0] rd,
                              input logic [DW-1:0] data, input logic full, input logic e);
    exp_t x;
    x.cyc = c; x.regw = regw; x.rd = rd; x.data = data; x.full = full; x.err = e;
    return x;
  endfunction

  // monitor: every retire must match the oldest expected write-back
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      chk("wb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("wb_cycle", mon_e.cyc, mon_e.cyc == cyc ? cyc : cyc);
        chk("wb_cycle_at", cyc, mon_e.cyc);
        chk("wb_regw", wb_regw, mon_e.regw);
        chk("wb_err", err, mon_e.err);
        if (mon_e.full) begin
          chk("wb_rd", wb_rd, mon_e.rd);
          chk("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  task automatic alu(input logic regw, input logic [RW-1:0] rd, input logic [DW-1:0] a);
    @(posedge clk); #1;
    ex_regw = regw; ex_memw = 1'b0; ex_memr = 1'b0;
    ex_rd = rd; ex_addr = a; ex_wdata = $urandom;
    mem_ack = 1'($urandom_range(0, 1));
    #1;
    chk("alu_stall", stall, 0);
    chk("alu_mem_req", mem_req, 0);
    if (regw) sb.push_back(mk(cyc + 1, 1'b1, rd, a, 1'b1, model_err));
  endtask

  // issue one memory op; memory answers after lat REQ cycles (lat > TO: never)
  task automatic memop(input logic st, input logic ld, input logic regw, input logic [RW-1:0] rd,
                       input logic [DW-1:0] a, input logic [DW-1:0] wd, input int lat);
    int            c0;
    int            k;
    logic          acked;
    logic [DW-1:0] rdat;
    @(posedge clk); #1;
    ex_regw = regw; ex_memw = st; ex_memr = ld;
    ex_rd = rd; ex_addr = a; ex_wdata = wd; mem_ack = 1'b0;
    #1;
    chk("det_stall", stall, 1);
    chk("det_mem_req", mem_req, 0);
    c0 = cyc; k = 0; acked = 1'b0; rdat = '0;
    while (!acked && k < TO) begin
      @(posedge clk); #1;
      k++;
      chk("req_mem_req", mem_req, 1);
      chk("req_stall", stall, 1);
      chk("req_we", mem_we, st);
      chk("req_addr", mem_addr, a);
      if (st) chk("req_wdata", mem_wdata, wd);
      rdat = $urandom;
      mem_rdata = rdat;
      mem_ack = (k == lat);
      if (k == lat) acked = 1'b1;
    end
    if (acked) begin
      if (st) sb.push_back(mk(c0 + lat + 1, 1'b0, rd, a, 1'b1, model_err));
      else    sb.push_back(mk(c0 + lat + 1, regw, rd, rdat, 1'b1, model_err));
    end else begin
      model_err = 1'b1;
      sb.push_back(mk(c0 + TO + 1, 1'b0, rd, '0, 1'b0, 1'b1));
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    #1;
    chk("rel_stall", stall, 0);
    chk("rel_mem_req", mem_req, 0);
  endtask

  int lats[6];

  initial begin
    lats = '{1, 2, 3, TO - 1, TO, TO + 5};
    reset = 1'b1;
    ex_regw = 1'b1; ex_memw = 1'b0; ex_memr = 1'b1;
    ex_addr = 32'h10; ex_wdata = '0; ex_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_regw", wb_regw, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", err, 0);
    ex_regw = 1'b0; ex_memr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    alu(1'b1, 4'd5, 32'h1234);
    memop(1'b0, 1'b1, 1'b1, 4'd3, 32'h40, 32'h0, 3);
    memop(1'b1, 1'b0, 1'b0, 4'd9, 32'h80, 32'h55, 1);
    memop(1'b1, 1'b1, 1'b1, 4'd2, 32'h84, 32'h77, 2);
    memop(1'b0, 1'b1, 1'b1, 4'd6, 32'h44, 32'h0, TO);
    alu(1'b0, 4'd1, 32'hBAD);
    memop(1'b0, 1'b1, 1'b1, 4'd4, 32'h48, 32'h0, TO + 5);
    alu(1'b1, 4'd8, 32'hCAFE);

    // reset in the second REQ cycle abandons the load
    @(posedge clk); #1;
    ex_regw = 1'b1; ex_memw = 1'b0; ex_memr = 1'b1; ex_rd = 4'd11; ex_addr = 32'h50; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_err", err, 0);
    model_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ex_regw = 1'b0; ex_memw = 1'b0; ex_memr = 1'b0;
    alu(1'b1, 4'd7, 32'h5A5A);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        alu(1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      end else begin
        logic st, ld;
        st = 1'($urandom_range(0, 1));
        ld = 1'($urandom_range(0, 1));
        if (!st && !ld) ld = 1'b1;
        memop(st, ld, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
              lats[$urandom_range(0, 5)]);
      end
    end

    @(posedge clk); #1;
    ex_regw = 1'b0; ex_memw = 1'b0; ex_memr = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
